regfile: RTL and testbench

- RV32 integer register file for the single-issue core: 32 architectural registers x0..x31, each DATA_WIDTH bits.
- Two asynchronous (combinational) read ports, rs1 and rs2, feed decode/execute.
- One synchronous write port, rd, is driven by writeback.
- x0 is hardwired to zero.

---
 rtl/regfile.sv | 65 ++++++
 tb/tb_regfile.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile : RV32 integer register file, 32 x DATA_WIDTH.
//   - Two combinational read ports (rs1, rs2), one synchronous write port (rd).
//   - x0 is hardwired to zero; writes to it are discarded.
//   - Asynchronous active-low reset clears every register.
//   - Optional build macro REGFILE_BYPASS_EN: forward rd_data to a read port
//     in the same cycle when that port reads the register being written.
// -----------------------------------------------------------------------------
module regfile #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  reg_write,
   output logic [DATA_WIDTH-1:0] rs1_data,
   output logic [DATA_WIDTH-1:0] rs2_data
);

   localparam int unsigned NREG = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NREG];

   // A write takes effect only out of reset, when enabled, and never for x0.
   logic wr_fire;
   assign wr_fire = rst_n & reg_write & (rd_addr != '0);

   // Register storage: async clear, rising-edge write of the addressed entry.
   // x0 is also cleared and never written, so it stays zero and folds away.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '{default: '0};
      end else if (wr_fire) begin
         regs[rd_addr] <= rd_data;
      end
   end

   // Combinational read ports; address 0 is forced to zero independently of
   // the storage so no earlier x0 write attempt can ever be observed.
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1_addr != '0) begin
         rs1_data = regs[rs1_addr];
      end
      if (rs2_addr != '0) begin
         rs2_data = regs[rs2_addr];
      end
`ifdef REGFILE_BYPASS_EN
      // Same-cycle forwarding of the pending write; wr_fire already excludes
      // x0, disabled writes and reset, so those cases keep the stored path.
      if (wr_fire && (rd_addr == rs1_addr)) begin
         rs1_data = rd_data;
      end
      if (wr_fire && (rd_addr == rs2_addr)) begin
         rs2_data = rd_data;
      end
`endif
   end

endmodule

// File: tb/tb_regfile.sv
// -----------------------------------------------------------------------------
// tb_regfile : self-checking bench for regfile.
//   Directed test-plan steps followed by randomized traffic, all checked
//   against an array-based reference model. Honours REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] rs1_addr;
   logic [AW-1:0] rs2_addr;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          reg_write;
   logic [DW-1:0] rs1_data;
   logic [DW-1:0] rs2_data;

   int errors;
   int checks;

   // Reference model: architectural contents of x0..x31.
   logic [DW-1:0] ref_mem [32];

   regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .reg_write (reg_write),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs,
                        input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected read value for a port, from the current model and inputs.
   function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (!rst_n) return '0;
`ifdef REGFILE_BYPASS_EN
      if (reg_write && rd_addr != 0 && rd_addr == a) return rd_data;
`endif
      return ref_mem[a];
   endfunction

   task automatic check_ports(input string tag);
      check({tag, "_rs1"}, rs1_data, exp_read(rs1_addr));
      check({tag, "_rs2"}, rs2_data, exp_read(rs2_addr));
   endtask

   // Model update on a rising edge.
   task automatic model_edge();
      if (rst_n && reg_write && rd_addr != 0) ref_mem[rd_addr] = rd_data;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
   endtask

   // One full cycle: drive after negedge, check before and after posedge.
   task automatic do_cycle(input logic we, input logic [AW-1:0] rd,
                           input logic [DW-1:0] d, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input string tag);
      @(negedge clk);
      reg_write = we;
      rd_addr   = rd;
      rd_data   = d;
      rs1_addr  = a1;
      rs2_addr  = a2;
      #1;
      check_ports({tag, "_pre"});
      @(posedge clk);
      model_edge();
      #1;
      check_ports({tag, "_post"});
   endtask

   task automatic read_all(input string tag);
      reg_write = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs1_addr = AW'(i);
         rs2_addr = AW'(31 - i);
         #1;
         check_ports(tag);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      model_clear();
      rst_n = 1'b0; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
      rs1_addr = '0; rs2_addr = '0;

      // Reset held with all inputs zero.
      #100;
      check("rst_rs1", rs1_data, 32'h0);
      check("rst_rs2", rs2_data, 32'h0);
      // Write attempted while in reset is ignored.
      do_cycle(1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd5, "rst_wr");
      check("rst_wr_x5", rs1_data, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      read_all("post_rst");

      // Writes then read, no extra edge.
      do_cycle(1'b1, 5'd1, 32'h12345678, 5'd0, 5'd0, "wr_x1");
      do_cycle(1'b1, 5'd2, 32'h87654321, 5'd0, 5'd0, "wr_x2");
      @(negedge clk);
      reg_write = 1'b0;
      rs1_addr = 5'd1;
      rs2_addr = 5'd2;
      #1;
      check("rd_x1", rs1_data, 32'h12345678);
      check("rd_x2", rs2_data, 32'h87654321);

      // x0 protection.
      do_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd1, "wr_x0");
      @(negedge clk);
      reg_write = 1'b0;
      rs1_addr = 5'd0;
      rs2_addr = 5'd2;
      #1;
      check("x0_zero", rs1_data, 32'h0);
      check("x2_keep", rs2_data, 32'h87654321);
      rs2_addr = 5'd1;
      #1;
      check("x1_keep", rs2_data, 32'h12345678);

      // Write enable low for several edges.
      for (int k = 0; k < 3; k++)
         do_cycle(1'b0, 5'd3, 32'hDEADBEEF, 5'd3, 5'd3, "we_low");
      check("x3_zero", rs1_data, 32'h0);

      // Same-address read during write.
      @(negedge clk);
      reg_write = 1'b1; rd_addr = 5'd1; rd_data = 32'hA5A5A5A5;
      rs1_addr = 5'd1; rs2_addr = 5'd1;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("same_pre_rs1", rs1_data, 32'hA5A5A5A5);
      check("same_pre_rs2", rs2_data, 32'hA5A5A5A5);
`else
      check("same_pre_rs1", rs1_data, 32'h12345678);
      check("same_pre_rs2", rs2_data, 32'h12345678);
`endif
      @(posedge clk);
      model_edge();
      #1;
      check("same_post_rs1", rs1_data, 32'hA5A5A5A5);
      check("same_post_rs2", rs2_data, 32'hA5A5A5A5);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         logic          we;
         logic [AW-1:0] rd, a1, a2;
         logic [DW-1:0] d;
         we = ($urandom_range(0, 3) != 0);
         rd = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(0, 31));
         d  = $urandom;
         a1 = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, 31));
         do_cycle(we, rd, d, a1, a2, "rand");
      end

      // Async reset mid-run, between clock edges, with a write presented.
      @(negedge clk);
      reg_write = 1'b0;
      rs1_addr = 5'd1;
      rs2_addr = 5'd2;
      #1;
      check_ports("pre_async");
      #1;
      rst_n = 1'b0;
      reg_write = 1'b1; rd_addr = 5'd1; rd_data = 32'h5A5A5A5A;
      model_clear();
      #1;
      check("async_rs1", rs1_data, 32'h0);
      check("async_rs2", rs2_data, 32'h0);
      @(posedge clk);
      model_edge();
      #1;
      check("async_wr_rs1", rs1_data, 32'h0);
      @(negedge clk);
      reg_write = 1'b0;
      rst_n = 1'b1;
      read_all("post_async");

      // A write after reset release still works.
      do_cycle(1'b1, 5'd31, 32'h0BADC0DE, 5'd31, 5'd30, "wr_x31");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
